// File: rtl/phy_rx_nrzi.sv
// USB 1.1 FS/LS receive path: SYNC hunt, NRZI decode, bit unstuffing and EOP detection.
// One line bit is consumed per rx_dat_en strobe; all outputs are registered.
module phy_rx_nrzi (
   input  logic clk,
   input  logic rst,
   input  logic rx_dat,
   input  logic rx_dat_en,
   input  logic rx_se0,
   output logic rx_nrzi_dat,
   output logic rx_nrzi_dat_en,
   output logic rx_active,
   output logic rx_eop,
   output logic rx_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SYNC = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_EOP  = 2'd3;

   logic [1:0] state, state_n;
   logic       prev_line, prev_line_n;
   logic [1:0] zero_cnt, zero_n;
   logic [2:0] ones_cnt, ones_n;
   logic [1:0] se0_cnt, se0_n;
   logic       dat_n, dat_en_n, active_n, eop_n, err_n;
   logic       to_idle;
   logic       d;

   // NRZI: no transition on the line decodes as 1
   assign d = (rx_dat == prev_line);

   always_comb begin
      state_n     = state;
      prev_line_n = prev_line;
      zero_n      = zero_cnt;
      ones_n      = ones_cnt;
      se0_n       = se0_cnt;
      dat_n       = rx_nrzi_dat;
      dat_en_n    = 1'b0;
      active_n    = rx_active;
      eop_n       = 1'b0;
      err_n       = 1'b0;
      to_idle     = 1'b0;

      if (rx_dat_en) begin
         if (!rx_se0) prev_line_n = rx_dat;

         case (state)
            ST_IDLE: begin
               if (!rx_se0 && !d) begin
                  state_n = ST_SYNC;
                  zero_n  = 2'd1;
               end
            end
            ST_SYNC: begin
               if (rx_se0) begin
                  to_idle = 1'b1;
               end else if (!d) begin
                  if (zero_cnt != 2'd3) zero_n = zero_cnt + 2'd1;
               end else if (zero_cnt == 2'd3) begin
                  // The closing 1 of SYNC is swallowed but starts the stuffing run
                  state_n  = ST_DATA;
                  ones_n   = 3'd1;
                  active_n = 1'b1;
               end else begin
                  to_idle = 1'b1;
               end
            end
            ST_DATA: begin
               if (rx_se0) begin
                  state_n = ST_EOP;
                  se0_n   = 2'd1;
               end else if (ones_cnt == 3'd6) begin
                  if (d) begin
                     err_n    = 1'b1;
                     active_n = 1'b0;
                     to_idle  = 1'b1;
                  end else begin
                     ones_n = 3'd0;
                  end
               end else begin
                  dat_n    = d;
                  dat_en_n = 1'b1;
                  ones_n   = d ? ones_cnt + 3'd1 : 3'd0;
               end
            end
            ST_EOP: begin
               if (rx_se0) begin
                  if (se0_cnt != 2'd3) se0_n = se0_cnt + 2'd1;
               end else begin
                  eop_n    = rx_dat;
                  err_n    = ~rx_dat;
                  active_n = 1'b0;
                  to_idle  = 1'b1;
               end
            end
            default: to_idle = 1'b1;
         endcase

         // Re-arming in IDLE always assumes the bus is parked at J
         if (to_idle) begin
            state_n     = ST_IDLE;
            prev_line_n = 1'b1;
            zero_n      = 2'd0;
            ones_n      = 3'd0;
            se0_n       = 2'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_IDLE;
         prev_line      <= 1'b1;
         zero_cnt       <= 2'd0;
         ones_cnt       <= 3'd0;
         se0_cnt        <= 2'd0;
         rx_nrzi_dat    <= 1'b0;
         rx_nrzi_dat_en <= 1'b0;
         rx_active      <= 1'b0;
         rx_eop         <= 1'b0;
         rx_err         <= 1'b0;
      end else begin
         state          <= state_n;
         prev_line      <= prev_line_n;
         zero_cnt       <= zero_n;
         ones_cnt       <= ones_n;
         se0_cnt        <= se0_n;
         rx_nrzi_dat    <= dat_n;
         rx_nrzi_dat_en <= dat_en_n;
         rx_active      <= active_n;
         rx_eop         <= eop_n;
         rx_err         <= err_n;
      end
   end

endmodule
